// File: rtl/tpu_mac_array_gen_if.sv
// Command/response bus of the MAC array engine: CFU funct code, two operand
// words in, read data and status out.
interface tpu_mac_array_gen_if #(
   parameter int N     = 4,
   parameter int ACC_W = 32
);
   logic [2:0]       funct;
   logic [8*N-1:0]   input0;
   logic [8*N-1:0]   input1;
   logic [ACC_W-1:0] C_output;
   logic             rd_valid;
   logic             busy;
   logic             done;
   logic             err;

   modport master (output funct, input0, input1,
                   input  C_output, rd_valid, busy, done, err);
   modport slave  (input  funct, input0, input1,
                   output C_output, rd_valid, busy, done, err);
endinterface

// File: rtl/tpu_mac_array_gen.sv
// NxN output-stationary int8 outer-product MAC engine behind the CFU decode.
// A/B words are buffered (depth K_DEPTH), START streams K of them through the
// array, then the accumulators drain into the C row buffer for readback.
// Optional build macro INPUT_OFFSET_EN: CFG latches a signed 9-bit zero-point
// from input1[8:0] that is added to every A lane before the multiply.

// One accumulator cell: acc += sext(a*b), wrapping.
module tpu_mac_cell #(
   parameter int LW    = 8,
   parameter int ACC_W = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   input  logic                 en,
   input  logic signed [LW-1:0] a,
   input  logic signed [7:0]    b,
   output logic [ACC_W-1:0]     acc
);
   logic signed [LW+7:0] prod;

   assign prod = a * b;

   // Clear on command, otherwise accumulate the sign-extended product
   always_ff @(posedge clk or posedge rst)
      if (rst)      acc <= '0;
      else if (clr) acc <= '0;
      else if (en)  acc <= acc + ACC_W'(prod);
endmodule

module tpu_mac_array_gen #(
   parameter int N       = 4,
   parameter int K_DEPTH = 2048,
   parameter int ACC_W   = 32
) (
   input logic              clk,
   input logic              rst_n,   // active-high asynchronous reset
   tpu_mac_array_gen_if.slave bus
);
   localparam logic [2:0] F_CFG    = 3'd1;
   localparam logic [2:0] F_WRITE  = 3'd2;
   localparam logic [2:0] F_READ   = 3'd3;
   localparam logic [2:0] F_CLRPTR = 3'd4;
   localparam logic [2:0] F_START  = 3'd6;
   localparam int AW = $clog2(K_DEPTH);
   localparam int RW = (N > 1) ? $clog2(N) : 1;
   localparam logic [AW:0] WPTR_FULL = K_DEPTH[AW:0];
   localparam logic [16:0] K_MAX     = K_DEPTH[16:0];
`ifdef INPUT_OFFSET_EN
   localparam int LW = 10;
`else
   localparam int LW = 8;
`endif

   typedef enum logic [1:0] {IDLE, COMPUTE, DRAIN, DONE} state_t;

   state_t           state;
   logic [15:0]      k_reg;
   logic [16:0]      k_ext;
   logic [AW:0]      wptr;
   logic [16:0]      cnt;
   logic [RW-1:0]    drn_row;
   logic             busy, done, err, rd_valid;
   logic [ACC_W-1:0] c_out;
   logic             mac_en, rd_en, acc_clr, wr_ok, idle_cmd;
`ifdef INPUT_OFFSET_EN
   logic signed [8:0] offset;
`endif

   logic [8*N-1:0] a_mem [K_DEPTH];
   logic [8*N-1:0] b_mem [K_DEPTH];
   logic [8*N-1:0] a_q, b_q;

   logic [N-1:0][N-1:0][ACC_W-1:0] acc;     // acc[row][col]
   logic [N-1:0][N-1:0][ACC_W-1:0] c_buf;   // c_buf[row][N-1-col]: col 0 at MSB
   logic [N-1:0][ACC_W-1:0]        drn_word;
   logic [15:0]                    rsel, csel;
   logic [ACC_W-1:0]               rd_data;

   assign k_ext    = {1'b0, k_reg};
   assign idle_cmd = !busy;
   assign rd_en    = (state == COMPUTE) && (cnt < k_ext);
   assign wr_ok    = idle_cmd && (bus.funct == F_WRITE) && (wptr != WPTR_FULL);
   assign acc_clr  = idle_cmd && (bus.funct == F_CFG || bus.funct == F_CLRPTR ||
                                  bus.funct == F_START);
   assign rsel     = bus.input0[15:0];
   assign csel     = bus.input1[15:0];

   assign bus.C_output = c_out;
   assign bus.rd_valid = rd_valid;
   assign bus.busy     = busy;
   assign bus.done     = done;
   assign bus.err      = err;

   // Operand buffers: write port from the CPU, 1-cycle read port for the stream
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         a_mem[wptr[AW-1:0]] <= bus.input0;
         b_mem[wptr[AW-1:0]] <= bus.input1;
      end
      if (rd_en) begin
         a_q <= a_mem[cnt[AW-1:0]];
         b_q <= b_mem[cnt[AW-1:0]];
      end
   end

   // NxN cell array; A lane i feeds row i, B lane j feeds column j (lane 0 = MSB byte)
   for (genvar i = 0; i < N; i++) begin : g_row
      logic signed [LW-1:0] a_op;
`ifdef INPUT_OFFSET_EN
      assign a_op = LW'($signed(a_q[8*(N-1-i) +: 8])) + LW'(offset);
`else
      assign a_op = a_q[8*(N-1-i) +: 8];
`endif
      for (genvar j = 0; j < N; j++) begin : g_col
         tpu_mac_cell #(.LW(LW), .ACC_W(ACC_W)) u_cell (
            .clk (clk),
            .rst (rst_n),
            .clr (acc_clr),
            .en  (mac_en),
            .a   (a_op),
            .b   (b_q[8*(N-1-j) +: 8]),
            .acc (acc[i][j])
         );
      end
   end

   // Row being drained, packed with column 0 in the top element
   always_comb begin
      drn_word = '0;
      for (int j = 0; j < N; j++) drn_word[N-1-j] = acc[drn_row][j];
   end

   // C element lookup for READ; out-of-range coordinates read as zero
   always_comb begin
      rd_data = '0;
      if (rsel < 16'(N) && csel < 16'(N))
         rd_data = c_buf[rsel[RW-1:0]][RW'(N-1) - csel[RW-1:0]];
   end

   // Control FSM with command decode and registered status outputs
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state    <= IDLE;
         k_reg    <= '0;
         wptr     <= '0;
         cnt      <= '0;
         drn_row  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         rd_valid <= 1'b0;
         c_out    <= '0;
         mac_en   <= 1'b0;
         c_buf    <= '0;
`ifdef INPUT_OFFSET_EN
         offset   <= '0;
`endif
      end else begin
         rd_valid <= 1'b0;
         mac_en   <= rd_en;
         case (state)
            COMPUTE: begin
               cnt <= cnt + 17'd1;
               if (cnt == k_ext) begin
                  state   <= DRAIN;
                  drn_row <= '0;
               end
            end
            DRAIN: begin
               c_buf[drn_row] <= drn_word;
               drn_row        <= drn_row + RW'(1);
               if (drn_row == RW'(N-1)) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: ;
         endcase

         if (busy) begin
            // Commands other than no-ops are refused while the array is running
            case (bus.funct)
               F_CFG, F_WRITE, F_CLRPTR, F_START: err <= 1'b1;
               F_READ: begin
                  err      <= 1'b1;
                  rd_valid <= 1'b1;
                  c_out    <= '0;
               end
               default: ;
            endcase
         end else begin
            case (bus.funct)
               F_CFG: begin
                  k_reg <= bus.input0[15:0];
                  c_buf <= '0;
                  err   <= 1'b0;
                  state <= IDLE;
                  done  <= 1'b0;
`ifdef INPUT_OFFSET_EN
                  offset <= bus.input1[8:0];
`endif
               end
               F_WRITE: begin
                  if (wptr == WPTR_FULL) err <= 1'b1;
                  else                   wptr <= wptr + 1'b1;
               end
               F_READ: begin
                  rd_valid <= 1'b1;
                  c_out    <= rd_data;
               end
               F_CLRPTR: wptr <= '0;
               F_START: begin
                  c_buf <= '0;
                  cnt   <= '0;
                  if (k_reg == 16'd0 || k_ext > K_MAX) begin
                     // Nothing to stream: finish immediately with C = 0
                     state <= DONE;
                     done  <= 1'b1;
                     if (k_ext > K_MAX) err <= 1'b1;
                  end else begin
                     state <= COMPUTE;
                     busy  <= 1'b1;
                     done  <= 1'b0;
                  end
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_tpu_mac_array_gen.sv
// Directed + randomized bench for tpu_mac_array_gen (N=4, K_DEPTH=4, ACC_W=32).
// Expected C values come from a plain dot-product model over the words the
// bench has written.
module tb_tpu_mac_array_gen;
   localparam int N  = 4;
   localparam int KD = 4;
   localparam logic [2:0] CFG = 3'd1, WR = 3'd2, RD = 3'd3, CLR = 3'd4, ST = 3'd6;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   checks = 0;
   int   errors = 0;

   logic [31:0] am [KD];
   logic [31:0] bm [KD];
   int          moff = 0;

   tpu_mac_array_gen_if #(.N(N), .ACC_W(32)) bus ();

   tpu_mac_array_gen #(.N(N), .K_DEPTH(KD), .ACC_W(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cmd(input logic [2:0] f, input logic [31:0] i0, input logic [31:0] i1);
      bus.funct  = f;
      bus.input0 = i0;
      bus.input1 = i1;
      @(posedge clk);
      #1;
      bus.funct  = 3'd0;
   endtask

   // Sum over k of (a_lane[r] + offset) * b_lane[c], wrapping at 32 bits
   function automatic logic [31:0] model(input int r, input int c, input int k);
      int s;
      s = 0;
      for (int x = 0; x < k; x++) begin
         logic [31:0]      aw, bw;
         logic signed [7:0] ab, bb;
         aw = am[x];
         bw = bm[x];
         ab = aw[8*(3-r) +: 8];
         bb = bw[8*(3-c) +: 8];
         s += (int'(ab) + moff) * int'(bb);
      end
      return s;
   endfunction

   task automatic set_offset(input logic [31:0] i1);
`ifdef INPUT_OFFSET_EN
      logic signed [8:0] o;
      o = i1[8:0];
      moff = int'(o);
`else
      moff = 0;
`endif
   endtask

   // Count busy cycles after a START already issued, bounded
   task automatic wait_idle(output int n);
      n = 0;
      while (bus.busy && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic load(input int cnt);
      cmd(CLR, 0, 0);
      for (int x = 0; x < cnt; x++) cmd(WR, am[x], bm[x]);
   endtask

   task automatic check_all(input string tag, input int k);
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            cmd(RD, r, c);
            chk(tag, bus.C_output, model(r, c, k));
         end
   endtask

   initial begin
      int n;
      int k;
      logic [31:0] w, cfg1;
      bus.funct = 3'd0; bus.input0 = '0; bus.input1 = '0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", {31'd0, bus.busy}, 0);
      chk("rst_done", {31'd0, bus.done}, 0);
      chk("rst_err", {31'd0, bus.err}, 0);
      chk("rst_cout", bus.C_output, 0);
      chk("rst_rdv", {31'd0, bus.rd_valid}, 0);
      rst_n = 1'b0;
      @(posedge clk); #1;

      // K=1 basic: busy for K+1+N = 6 cycles, then C[2][3] = 3*1
      am[0] = 32'h01020304; bm[0] = 32'h01010101;
      cmd(CFG, 1, 0); set_offset(0);
      load(1);
      cmd(ST, 0, 0);
      chk("k1_busy_rise", {31'd0, bus.busy}, 1);
      wait_idle(n);
      chk("k1_busy_len", n, 6);
      chk("k1_done", {31'd0, bus.done}, 1);
      cmd(RD, 2, 3);
      chk("k1_rdv", {31'd0, bus.rd_valid}, 1);
      chk("k1_c23", bus.C_output, 32'd3);
      @(posedge clk); #1;
      chk("k1_rdv_pulse", {31'd0, bus.rd_valid}, 0);

      // K=2 negative products: -1*127 twice
      am[0] = 32'hFF000000; bm[0] = 32'h7F000000;
      am[1] = 32'hFF000000; bm[1] = 32'h7F000000;
      cmd(CFG, 2, 0);
      load(2);
      cmd(ST, 0, 0);
      wait_idle(n);
      chk("k2_busy_len", n, 7);
      cmd(RD, 0, 0);
      chk("k2_c00", bus.C_output, 32'hFFFFFF02);

      // K=0: done immediately, busy never high, C reads 0 with no err
      cmd(CFG, 0, 0);
      cmd(ST, 0, 0);
      chk("k0_done", {31'd0, bus.done}, 1);
      chk("k0_busy", {31'd0, bus.busy}, 0);
      cmd(RD, 0, 0);
      chk("k0_c00", bus.C_output, 0);
      cmd(RD, 3, 3);
      chk("k0_c33", bus.C_output, 0);
      chk("k0_err", {31'd0, bus.err}, 0);

      // Out-of-range READ still pulses rd_valid and returns 0
      cmd(RD, 4, 0);
      chk("oor_rdv", {31'd0, bus.rd_valid}, 1);
      chk("oor_c", bus.C_output, 0);

      // Buffer overflow: fifth WRITE dropped, err set
      for (int x = 0; x < KD; x++) begin am[x] = $urandom; bm[x] = $urandom; end
      cmd(CFG, KD, 0);
      load(KD);
      chk("ovf_err_before", {31'd0, bus.err}, 0);
      cmd(WR, 32'h7F7F7F7F, 32'h7F7F7F7F);
      chk("ovf_err_after", {31'd0, bus.err}, 1);
      // Commands while busy are refused; results unaffected
      cmd(CFG, KD, 0);
      chk("cfg_clr_err", {31'd0, bus.err}, 0);
      cmd(ST, 0, 0);
      cmd(WR, 32'h11111111, 32'h22222222);
      chk("busy_wr_err", {31'd0, bus.err}, 1);
      cmd(RD, 0, 0);
      chk("busy_rd_rdv", {31'd0, bus.rd_valid}, 1);
      chk("busy_rd_c", bus.C_output, 0);
      wait_idle(n);
      chk("ovf_done", {31'd0, bus.done}, 1);
      check_all("ovf_c", KD);

      // K > K_DEPTH: done at once, err set, C zero
      cmd(CFG, KD + 1, 0);
      cmd(ST, 0, 0);
      chk("kbig_done", {31'd0, bus.done}, 1);
      chk("kbig_err", {31'd0, bus.err}, 1);
      cmd(RD, 1, 2);
      chk("kbig_c", bus.C_output, 0);

      // Randomized runs, plus re-START from DONE must give the same C
      for (int it = 0; it < 6; it++) begin
         k = $urandom_range(1, KD);
         for (int x = 0; x < k; x++) begin am[x] = $urandom; bm[x] = $urandom; end
         cfg1 = $urandom;
         cmd(CFG, k, cfg1); set_offset(cfg1);
         load(k);
         cmd(ST, 0, 0);
         wait_idle(n);
         chk("rnd_busy_len", n, k + 1 + N);
         chk("rnd_done", {31'd0, bus.done}, 1);
         check_all("rnd_c", k);
         if (it == 0) begin
            cmd(ST, 0, 0);
            wait_idle(n);
            check_all("restart_c", k);
         end
      end

      // Async reset mid-COMPUTE
      w = 32'h7F7F7F7F;
      for (int x = 0; x < KD; x++) begin am[x] = w; bm[x] = w; end
      cmd(CFG, KD, 0); set_offset(0);
      load(KD);
      cmd(ST, 0, 0);
      wait_idle(n);
      cmd(RD, 0, 0);
      chk("pre_rst_c", bus.C_output, model(0, 0, KD));
      cmd(ST, 0, 0);
      cmd(WR, 0, 0);
      #2 rst_n = 1'b1;
      #1;
      chk("arst_busy", {31'd0, bus.busy}, 0);
      chk("arst_done", {31'd0, bus.done}, 0);
      chk("arst_err", {31'd0, bus.err}, 0);
      chk("arst_cout", bus.C_output, 0);
      @(posedge clk); #1;
      rst_n = 1'b0;
      cmd(RD, 0, 0);
      chk("post_rst_c00", bus.C_output, 0);
      chk("post_rst_rdv", {31'd0, bus.rd_valid}, 1);

`ifdef INPUT_OFFSET_EN
      am[0] = 32'h80808080; bm[0] = 32'h05050505;
      cmd(CFG, 1, 128); set_offset(128);
      load(1);
      cmd(ST, 0, 0);
      wait_idle(n);
      cmd(RD, 1, 1);
      chk("off128_c", bus.C_output, 0);
      cmd(CFG, 1, 1); set_offset(1);
      cmd(ST, 0, 0);
      wait_idle(n);
      cmd(RD, 2, 0);
      chk("off1_c", bus.C_output, 32'hFFFFFD85);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/tpu_mac_array_gen.md
Name: tpu_mac_array_gen

Overview:
Parametrised successor to the fixed 4x4 int8 CFU matrix engine. Holds A and B operand buffers of depth K_DEPTH. On START it streams K buffered words through an NxN output-stationary outer-product MAC array, then drains the accumulators into an N-row C buffer. The CPU reads C back one 32-bit element at a time. It sits behind the CFU command decode and is driven by the same 3-bit funct codes.

Parameters:
N, 4, array dimension; A/B word = N int8 lanes; C = NxN accumulators
K_DEPTH, 2048, A/B buffer depth in words (power of two)
ACC_W, 32, accumulator width in bits (>=16)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-high (asserted = 1)
funct  in  3  command: 1 CFG, 2 WRITE, 3 READ, 4 CLRPTR, 6 START; 0/5/7 no-op
input0  in  8*N  CFG: K in [15:0]; WRITE: A word; READ: row in [15:0]
input1  in  8*N  WRITE: B word; READ: column in [15:0]
C_output  out  ACC_W  read data
rd_valid  out  1  one-cycle pulse, one cycle after each READ
busy  out  1  high in COMPUTE and DRAIN
done  out  1  high in DONE state
err  out  1  sticky error flag

Behaviour:
- Reset: FSM=IDLE; K=0; write pointer=0; accumulators, C buffer and all outputs = 0.
- Lanes: lane i = bits [8(N-1-i)+7 : 8(N-1-i)], so lane 0 is the MSB byte. Lanes are signed int8.
- MAC: acc[i][j] += sext(a[i]*b[j]). The product is 16-bit signed. Accumulation wraps modulo 2^ACC_W with no saturation.
- CFG (IDLE or DONE only): K <= input0[15:0]; clear accumulators, C buffer and err; next state IDLE.
- WRITE (not busy): A[wptr] <= input0, B[wptr] <= input1, wptr++.
  - At wptr == K_DEPTH the write is dropped and err is set. The pointer does not wrap.
- CLRPTR (not busy): wptr <= 0; accumulators cleared. Buffer contents are kept.
- START (IDLE or DONE):
  - K == 0 or K > K_DEPTH: go to DONE without computing; C is all zeros; K > K_DEPTH also sets err.
  - Otherwise go to COMPUTE.
- States:
  - IDLE: waits for START.
  - COMPUTE: reads index 0..K-1, one per cycle. The buffers have 1-cycle synchronous read latency, so the MAC for index k happens the cycle after its read. Lasts K+1 cycles.
  - DRAIN: writes C row r = {acc[r][0] .. acc[r][N-1]} (column 0 at MSB) for r = 0..N-1, one row per cycle. Lasts N cycles.
  - DONE: holds until CFG or START. A re-START recomputes from freshly cleared accumulators.
- Latency: busy rises the cycle after START and stays high exactly K+1+N cycles. done rises the following cycle.
- READ:
  - Normal case: C_output <= C[row][col] and rd_valid pulses, both one cycle later.
  - row >= N or col >= N: C_output = 0, rd_valid still pulses.
  - READ while busy: C_output = 0, rd_valid pulses, err is set.
- CFG, WRITE, CLRPTR or START while busy: ignored, err set. The operation continues unaffected.
- Reset mid-COMPUTE/DRAIN: immediate return to the reset state; partial results are discarded.
- Only one funct per cycle; funct is sampled on rising clk.

Optional Feature:
INPUT_OFFSET_EN:
- Defined: CFG also latches a signed 9-bit offset from input1[8:0]. Every A lane becomes a[i]+offset (10-bit signed) before the multiply, for TFLite input zero-point. Product width becomes 18 bits, sign-extended to ACC_W.
- Undefined: no offset logic; input1 is ignored on CFG.

Test Plan:
- N=4, CFG K=1; WRITE A=0x01020304, B=0x01010101; START -> busy high 6 cycles then done; READ(2,3) -> C_output=3, rd_valid 1 cycle later.
- CFG K=2; WRITE A=0xFF000000, B=0x7F000000 twice; START -> READ(0,0) = -254 (0xFFFFFF02).
- CFG K=0; START -> done the next cycle with busy never high; every READ returns 0 with no err.
- K_DEPTH=4: five WRITEs -> err=1 after the fifth and A[3] unchanged; a WRITE during COMPUTE -> err=1 and results still correct.
- rst_n asserted mid-COMPUTE -> busy/done/err/C_output = 0 asynchronously; a subsequent READ(0,0) returns 0.
- INPUT_OFFSET_EN, offset=128, K=1, A=0x80808080 (-128), B=0x05050505 -> all C = 0; offset=1 -> all C = -635.
